spi_instr_sequencer: RTL and testbench
======================================

Name: spi_instr_sequencer

Overview:
- Executes commands written over SPI to the instruction register (address 2).
- Decodes each new instruction byte and turns it into timed control pulses for the analog front end: soft reset, forced trigger, and a per-channel scan over trigger_channel_mask (address 1).
- Reports progress through a status byte wired to read-only reg4 on the SPI readout path.
- Sits beside the SPI peripheral in the sclk domain. It runs only while sclk toggles, so the host clocks dummy bytes to let a sequence complete.

Parameters:
- PULSE_LEN, 4: sclk cycles for which soft_rstn_out / trig_pulse are held active (range 1..255).
- SETTLE_CYC, 2: sclk cycles between ch_sel change and ch_strobe (range 0..15).
- NUM_CH, 8: channel count; equals trigger_channel_mask width.

Ports:
- sclk  in  1  SPI clock; all state on its rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- instr_we  in  1  one-cycle strobe: instruction register written this cycle (input_mux latch bit 1).
- instr  in  8  instruction byte.
- trigger_ch_mask  in  NUM_CH  channel enable mask (address 1).
- mode  in  8  mode byte (address 3); bit0 = repeat scan.
- busy  out  1  sequence in progress.
- soft_rstn_out  out  1  active-low soft reset pulse to the core.
- trig_pulse  out  1  forced trigger pulse.
- ch_sel  out  $clog2(NUM_CH)  currently selected channel.
- ch_strobe  out  1  one-cycle per-channel strobe.
- status  out  8  status byte to reg4.
- cmd_count  out  8  accepted-command counter (see Optional Feature).

Behaviour:
Reset values:
- While rstn is low: busy=0, soft_rstn_out=1, trig_pulse=0, ch_sel=0, ch_strobe=0, status=0x00, cmd_count=0, state=IDLE.
- Reset mid-sequence aborts the sequence immediately and asynchronously.

Opcodes:
- 0x00 NOP.
- 0x01 SOFT_RST.
- 0x02 FORCE_TRIG.
- 0x03 SCAN.
- 0x04 ABORT.
- Any other value is unknown.

Command acceptance:
- All outputs are registered. A command is sampled on the edge where instr_we=1.
- The new state and outputs become visible after that edge (latency 1 cycle).
- In IDLE, a valid non-NOP, non-ABORT command is accepted:
  - busy=1.
  - done/err/reject are cleared.
  - cmd_count is incremented.
- NOP and ABORT in IDLE: no effect.
- Unknown opcode in any state: status err set, no other effect.

State machine:
- RST_PULSE: soft_rstn_out=0 for exactly PULSE_LEN cycles, then IDLE with done=1.
- TRIG_PULSE: trig_pulse=1 for exactly PULSE_LEN cycles, then IDLE with done=1.
- SCAN:
  - On entry, snapshot trigger_ch_mask and mode[0] into internal registers. Later writes to either have no effect on the running scan.
  - SCAN_FIND (1 cycle): ch_sel = lowest set bit of the remaining mask. If the remaining mask is empty:
    - repeat=1: reload the snapshot mask and continue.
    - repeat=0: go to IDLE, done=1.
    - An all-zero snapshot finishes in 1 cycle even with repeat=1 (no infinite loop).
  - SCAN_SETTLE: SETTLE_CYC cycles; skipped when SETTLE_CYC=0.
  - SCAN_STROBE (1 cycle): ch_strobe=1, clear that bit from the remaining mask, return to SCAN_FIND.
- ch_sel holds its last value in IDLE.

Commands while busy:
- ABORT: next state IDLE; soft_rstn_out=1, trig_pulse=0, ch_strobe=0; done is not set.
- Any other valid opcode: ignored, status reject set.
- ABORT and sequence completion on the same edge: ABORT wins, done=0.

Status bits:
- [0] busy.
- [1] done (sticky).
- [2] err (sticky).
- [3] reject (sticky).
- [6:4] ch_sel[2:0].
- [7] repeat-scan active.
- Sticky bits clear only on reset or on the next accepted command.

Optional Feature:
- Macro SEQ_CMD_COUNT_EN.
- Defined: cmd_count increments by 1 per accepted command and wraps 255→0.
- Undefined: the counter logic is not built and cmd_count is tied to 0. The port is present in both builds.

Decomposition:
- Package spi_seq_pkg holds:
  - opcode enum (8-bit);
  - state enum (IDLE, RST_PULSE, TRIG_PULSE, SCAN_FIND, SCAN_SETTLE, SCAN_STROBE);
  - status bit index constants.
- One sub-module, seq_pulse_timer:
  - 8-bit down-counter, loaded with a length;
  - emits a done flag on terminal count;
  - shared by the pulse states and the settle state.

Test Plan:
- Reset: rstn low mid-scan → all outputs return to their reset values asynchronously; status=0x00.
- Soft reset: instr_we with 0x01, PULSE_LEN=4 → busy=1 from next edge; soft_rstn_out low exactly 4 cycles; then status=0x02.
- Scan: mask=0x85, SETTLE_CYC=2, mode=0 → ch_strobe pulses with ch_sel=0, 2, 7, spaced 4 cycles apart; then done=1, busy=0.
- Mask change mid-scan: rewrite mask to 0xFF during the scan → still exactly 3 strobes.
- Busy collisions:
  - 0x02 written during RST_PULSE → ignored, status bit3=1.
  - 0x04 during a repeat scan (mode=0x01) → IDLE next cycle, no further strobes, done=0.
- Unknown opcode / zero-mask scan:
  - 0x7F → status=0x04, no pulses.
  - SCAN with mask=0x00, mode=0x01 → busy for 1 cycle, then done=1.
  - Optional Feature: with SEQ_CMD_COUNT_EN defined, 256 accepted commands → cmd_count wraps to 0.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// +----------------------------------------------------------------------+
// | spi_seq_pkg: opcodes, FSM states and status bit positions            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package spi_seq_pkg;

   typedef enum logic [7:0] {
      OP_NOP        = 8'h00,
      OP_SOFT_RST   = 8'h01,
      OP_FORCE_TRIG = 8'h02,
      OP_SCAN       = 8'h03,
      OP_ABORT      = 8'h04
   } opcode_e;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      RST_PULSE   = 3'd1,
      TRIG_PULSE  = 3'd2,
      SCAN_FIND   = 3'd3,
      SCAN_SETTLE = 3'd4,
      SCAN_STROBE = 3'd5
   } state_e;

   localparam int unsigned STAT_BUSY   = 0;
   localparam int unsigned STAT_DONE   = 1;
   localparam int unsigned STAT_ERR    = 2;
   localparam int unsigned STAT_REJECT = 3;
   localparam int unsigned STAT_CH_LSB = 4;
   localparam int unsigned STAT_REPEAT = 7;

   function automatic logic op_is_valid(input logic [7:0] op);
      return (op <= 8'(OP_ABORT));
   endfunction

endpackage

`default_nettype wire

// File: rtl/seq_pulse_timer.sv
// +----------------------------------------------------------------------+
// | seq_pulse_timer: 8-bit loadable down-counter, done on terminal count  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module seq_pulse_timer (
   input  logic       sclk,
   input  logic       rstn,
   input  logic       load_i,
   input  logic [7:0] len_i,
   output logic       done_o
);

   logic [7:0] cnt_q;

   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= 8'd0;
      end else if (load_i) begin
         cnt_q <= len_i;
      end else if (cnt_q != 8'd0) begin
         cnt_q <= cnt_q - 8'd1;
      end
   end

   // A load of N yields done during the N-th cycle after the load edge.
   assign done_o = (cnt_q == 8'd1);

endmodule

`default_nettype wire

// File: rtl/spi_instr_sequencer.sv
// +----------------------------------------------------------------------+
// | spi_instr_sequencer: SPI instruction decode into AFE control pulses  |
// | Optional macro SEQ_CMD_COUNT_EN builds the accepted-command counter. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module spi_instr_sequencer
   import spi_seq_pkg::*;
#(
   parameter int unsigned PULSE_LEN  = 4,
   parameter int unsigned SETTLE_CYC = 2,
   parameter int unsigned NUM_CH     = 8
) (
   input  logic                      sclk,
   input  logic                      rstn,
   input  logic                      instr_we,
   input  logic [7:0]                instr,
   input  logic [NUM_CH-1:0]         trigger_ch_mask,
   input  logic [7:0]                mode,
   output logic                      busy,
   output logic                      soft_rstn_out,
   output logic                      trig_pulse,
   output logic [$clog2(NUM_CH)-1:0] ch_sel,
   output logic                      ch_strobe,
   output logic [7:0]                status,
   output logic [7:0]                cmd_count
);

   localparam int unsigned CW = $clog2(NUM_CH);

   state_e            state_q;
   logic              busy_q, srst_n_q, trig_q, strobe_q;
   logic              done_q, err_q, rej_q, rep_q;
   logic [CW-1:0]     ch_sel_q;
   logic [NUM_CH-1:0] snap_q, rem_q;

   logic       cmd_unknown, cmd_accept, cmd_abort, cmd_reject;
   logic       tmr_load, tmr_done;
   logic [7:0] tmr_len;
   logic       unused_mode;

   assign unused_mode = ^mode[7:1];

   function automatic logic [CW-1:0] lowest_set(input logic [NUM_CH-1:0] m);
      lowest_set = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (m[i]) lowest_set = CW'(i);
      end
   endfunction

   always_comb begin
      cmd_unknown = instr_we && !op_is_valid(instr);
      cmd_accept  = instr_we && op_is_valid(instr) && (state_q == IDLE)
                    && (instr != 8'(OP_NOP)) && (instr != 8'(OP_ABORT));
      cmd_abort   = instr_we && (state_q != IDLE) && (instr == 8'(OP_ABORT));
      cmd_reject  = instr_we && op_is_valid(instr) && (state_q != IDLE)
                    && (instr != 8'(OP_ABORT));
      tmr_load    = 1'b0;
      tmr_len     = 8'd0;
      if (cmd_accept && (instr != 8'(OP_SCAN))) begin
         tmr_load = 1'b1;
         tmr_len  = 8'(PULSE_LEN);
      end else if (!cmd_abort && (state_q == SCAN_FIND) && (rem_q != '0)
                   && (SETTLE_CYC != 0)) begin
         tmr_load = 1'b1;
         tmr_len  = 8'(SETTLE_CYC);
      end
   end

   seq_pulse_timer u_timer (
      .sclk   (sclk),
      .rstn   (rstn),
      .load_i (tmr_load),
      .len_i  (tmr_len),
      .done_o (tmr_done)
   );

   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         srst_n_q <= 1'b1;
         trig_q   <= 1'b0;
         strobe_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         rej_q    <= 1'b0;
         rep_q    <= 1'b0;
         ch_sel_q <= '0;
         snap_q   <= '0;
         rem_q    <= '0;
      end else begin
         if (cmd_unknown) err_q <= 1'b1;
         if (cmd_reject)  rej_q <= 1'b1;

         // Abort takes priority over any completion on the same edge.
         if (cmd_abort) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            srst_n_q <= 1'b1;
            trig_q   <= 1'b0;
            strobe_q <= 1'b0;
            rep_q    <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (cmd_accept) begin
                     busy_q <= 1'b1;
                     done_q <= 1'b0;
                     err_q  <= 1'b0;
                     rej_q  <= 1'b0;
                     if (instr == 8'(OP_SOFT_RST)) begin
                        state_q  <= RST_PULSE;
                        srst_n_q <= 1'b0;
                     end else if (instr == 8'(OP_FORCE_TRIG)) begin
                        state_q <= TRIG_PULSE;
                        trig_q  <= 1'b1;
                     end else begin
                        state_q <= SCAN_FIND;
                        snap_q  <= trigger_ch_mask;
                        rem_q   <= trigger_ch_mask;
                        rep_q   <= mode[0];
                     end
                  end
               end
               RST_PULSE: begin
                  if (tmr_done) begin
                     state_q  <= IDLE;
                     busy_q   <= 1'b0;
                     srst_n_q <= 1'b1;
                     done_q   <= 1'b1;
                  end
               end
               TRIG_PULSE: begin
                  if (tmr_done) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     trig_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
               SCAN_FIND: begin
                  if (rem_q != '0) begin
                     ch_sel_q <= lowest_set(rem_q);
                     if (SETTLE_CYC == 0) begin
                        state_q  <= SCAN_STROBE;
                        strobe_q <= 1'b1;
                     end else begin
                        state_q <= SCAN_SETTLE;
                     end
                  end else if (rep_q && (snap_q != '0)) begin
                     rem_q <= snap_q;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     rep_q   <= 1'b0;
                  end
               end
               SCAN_SETTLE: begin
                  if (tmr_done) begin
                     state_q  <= SCAN_STROBE;
                     strobe_q <= 1'b1;
                  end
               end
               SCAN_STROBE: begin
                  strobe_q        <= 1'b0;
                  rem_q[ch_sel_q] <= 1'b0;
                  state_q         <= SCAN_FIND;
               end
               default: begin
                  state_q  <= IDLE;
                  busy_q   <= 1'b0;
                  srst_n_q <= 1'b1;
                  trig_q   <= 1'b0;
                  strobe_q <= 1'b0;
                  rep_q    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy          = busy_q;
   assign soft_rstn_out = srst_n_q;
   assign trig_pulse    = trig_q;
   assign ch_sel        = ch_sel_q;
   assign ch_strobe     = strobe_q;

   always_comb begin
      status                       = 8'h00;
      status[STAT_BUSY]            = busy_q;
      status[STAT_DONE]            = done_q;
      status[STAT_ERR]             = err_q;
      status[STAT_REJECT]          = rej_q;
      status[STAT_CH_LSB +: 3]     = 3'(ch_sel_q);
      status[STAT_REPEAT]          = rep_q;
   end

`ifdef SEQ_CMD_COUNT_EN
   logic [7:0] cmd_cnt_q;

   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         cmd_cnt_q <= 8'd0;
      end else if (cmd_accept) begin
         cmd_cnt_q <= cmd_cnt_q + 8'd1;
      end
   end

   assign cmd_count = cmd_cnt_q;
`else
   assign cmd_count = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_instr_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_spi_instr_sequencer: directed vector bench for the sequencer      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_spi_instr_sequencer;

   logic       sclk = 1'b0;
   logic       rstn = 1'b0;
   logic       instr_we = 1'b0;
   logic [7:0] instr = 8'h00;
   logic [7:0] trigger_ch_mask = 8'h00;
   logic [7:0] mode = 8'h00;
   logic       busy, soft_rstn_out, trig_pulse, ch_strobe;
   logic [2:0] ch_sel;
   logic [7:0] status, cmd_count;

   int n_pass  = 0;
   int n_total = 0;

   spi_instr_sequencer #(
      .PULSE_LEN  (4),
      .SETTLE_CYC (2),
      .NUM_CH     (8)
   ) dut (
      .sclk            (sclk),
      .rstn            (rstn),
      .instr_we        (instr_we),
      .instr           (instr),
      .trigger_ch_mask (trigger_ch_mask),
      .mode            (mode),
      .busy            (busy),
      .soft_rstn_out   (soft_rstn_out),
      .trig_pulse      (trig_pulse),
      .ch_sel          (ch_sel),
      .ch_strobe       (ch_strobe),
      .status          (status),
      .cmd_count       (cmd_count)
   );

   always #5 sclk = ~sclk;

   typedef struct {
      logic       we;
      logic [7:0] op;
      logic       e_busy;
      logic       e_srst_n;
      logic       e_trig;
      logic [7:0] e_status;
   } vec_t;

   vec_t vt[13];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   // Drive at the falling edge, then sample 1 time unit after the rising edge.
   task automatic step(input logic we, input logic [7:0] op);
      @(negedge sclk);
      instr_we = we;
      instr    = op;
      @(posedge sclk);
      #1;
   endtask

   int s_ch[8];
   int s_cyc[8];
   int ns;
   int nb;

   initial begin
      vt[0]  = '{1'b1, 8'h7F, 1'b0, 1'b1, 1'b0, 8'h04};
      vt[1]  = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 8'h01};
      vt[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h01};
      vt[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h01};
      vt[4]  = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 8'h09};
      vt[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h0A};
      vt[6]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h0A};
      vt[7]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 8'h0A};
      vt[8]  = '{1'b1, 8'h02, 1'b1, 1'b1, 1'b1, 8'h01};
      vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01};
      vt[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01};
      vt[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01};
      vt[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h02};

      #12;
      chk("reset_outputs", {busy, soft_rstn_out, trig_pulse, ch_sel, ch_strobe},
          {1'b0, 1'b1, 1'b0, 3'd0, 1'b0});
      chk("reset_status", status, 8'h00);
      chk("reset_cmd_count", cmd_count, 8'h00);
      @(negedge sclk);
      rstn = 1'b1;

      // Unknown, soft reset with busy collision, idle NOP/ABORT, forced trigger
      for (int i = 0; i < 13; i++) begin
         step(vt[i].we, vt[i].op);
         chk($sformatf("vec%0d", i),
             {busy, soft_rstn_out, trig_pulse, ch_strobe, ch_sel, status},
             {vt[i].e_busy, vt[i].e_srst_n, vt[i].e_trig, 1'b0, 3'd0, vt[i].e_status});
      end
`ifndef SEQ_CMD_COUNT_EN
      chk("cmd_count_tied", cmd_count, 8'h00);
`endif

      // Scan 0x85, mask rewritten mid-scan
      trigger_ch_mask = 8'h85;
      mode            = 8'h00;
      step(1'b1, 8'h03);
      chk("scan_start", {busy, status[7]}, 2'b10);
      ns = 0;
      for (int k = 1; k <= 40; k++) begin
         if (k == 2) trigger_ch_mask = 8'hFF;
         step(1'b0, 8'h00);
         if (ch_strobe && ns < 8) begin
            s_ch[ns]  = int'(ch_sel);
            s_cyc[ns] = k;
            ns++;
         end
         if (!busy) break;
      end
      chk("scan_done_busy", busy, 1'b0);
      chk("scan_strobe_count", ns, 3);
      if (ns == 3) begin
         chk("scan_ch_list", {s_ch[0][3:0], s_ch[1][3:0], s_ch[2][3:0]}, 12'h027);
         chk("scan_first_strobe_cyc", s_cyc[0], 3);
         chk("scan_spacing", {s_cyc[1] - s_cyc[0], s_cyc[2] - s_cyc[1]}, {32'd4, 32'd4});
      end
      chk("scan_status", status, 8'h72);

      // Repeat scan aborted while running
      trigger_ch_mask = 8'h03;
      mode            = 8'h01;
      step(1'b1, 8'h03);
      chk("rep_start", {busy, status[7]}, 2'b11);
      nb = 0;
      for (int k = 0; k < 20; k++) begin
         step(1'b0, 8'h00);
         if (ch_strobe) nb++;
      end
      chk("rep_strobes_gt2", (nb > 2), 1'b1);
      step(1'b1, 8'h04);
      chk("abort_state", {busy, ch_strobe, soft_rstn_out, trig_pulse, status[7], status[1]},
          6'b001000);
      nb = 0;
      for (int k = 0; k < 20; k++) begin
         step(1'b0, 8'h00);
         if (ch_strobe || busy) nb++;
      end
      chk("abort_quiet", nb, 0);

      // Zero mask with repeat finishes immediately
      trigger_ch_mask = 8'h00;
      mode            = 8'h01;
      step(1'b1, 8'h03);
      chk("zero_scan_busy", busy, 1'b1);
      step(1'b0, 8'h00);
      chk("zero_scan_done", {busy, status[1], status[7]}, 3'b010);

      // Asynchronous reset in the middle of a scan
      trigger_ch_mask = 8'hFF;
      mode            = 8'h01;
      step(1'b1, 8'h03);
      for (int k = 0; k < 6; k++) step(1'b0, 8'h00);
      chk("pre_reset_ch_sel", ch_sel, 3'd1);
      #2;
      rstn = 1'b0;
      #1;
      chk("async_reset_outputs", {busy, soft_rstn_out, trig_pulse, ch_sel, ch_strobe},
          {1'b0, 1'b1, 1'b0, 3'd0, 1'b0});
      chk("async_reset_status", status, 8'h00);
      chk("async_reset_cmd_count", cmd_count, 8'h00);
      @(negedge sclk);
      rstn = 1'b1;

`ifdef SEQ_CMD_COUNT_EN
      mode = 8'h00;
      step(1'b1, 8'h01);
      chk("cmd_count_one", cmd_count, 8'd1);
      for (int k = 0; k < 4; k++) step(1'b0, 8'h00);
      for (int c = 1; c < 256; c++) begin
         step(1'b1, 8'h01);
         for (int k = 0; k < 4; k++) step(1'b0, 8'h00);
      end
      chk("cmd_count_wrap", cmd_count, 8'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
